reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; SHALL match the ALU32 operand width.
REQ-002 Parameter ADDR_W, default 5, register address width; SHALL give 2**ADDR_W registers.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 ra1  input  ADDR_W  read-port-1 address (ALU operand A source).
REQ-006 ra2  input  ADDR_W  read-port-2 address (ALU operand B source).
REQ-007 rd1  output  WIDTH  read-port-1 data, drives ALU A.
REQ-008 rd2  output  WIDTH  read-port-2 data, drives ALU B.
REQ-009 we  input  1  register write enable (writeback of ALU result).
REQ-010 wa  input  ADDR_W  write address.
REQ-011 wd  input  WIDTH  write data, normally ALU result.
REQ-012 flag_we  input  1  status-flag write enable.
REQ-013 cout_in  input  1  ALU Cout to capture.
REQ-014 zero_in  input  1  ALU zero to capture.
REQ-015 carry_q  output  1  stored carry flag, drives ALU Cin.
REQ-016 zero_q  output  1  stored zero flag, for branch logic.
REQ-017 wr_cnt  output  16  count of committed register writes since reset.

Function
REQ-018 Storage SHALL be 2**ADDR_W registers of WIDTH bits; register 0 SHALL always read 0 and SHALL never be written.
REQ-019 Reads SHALL be combinational: rd1/rd2 reflect ra1/ra2 in the same cycle, with zero clock latency.
REQ-020 Bypass: when we=1, wa!=0 and ra1==wa, rd1 SHALL equal wd in that cycle; rd2 likewise for ra2.
REQ-021 Write: on rising clk with rst=0, we=1 and wa!=0, reg[wa] SHALL load wd; visible on the registered path the next cycle.
REQ-022 we=1 with wa=0 SHALL change no register and SHALL NOT increment wr_cnt.
REQ-023 wr_cnt SHALL increment by 1 per committed write (REQ-021), wrap from 0xFFFF to 0x0000, and saturate never.
REQ-024 Flags: on rising clk with rst=0 and flag_we=1, carry_q<=cout_in and zero_q<=zero_in; otherwise hold.
REQ-025 Register writes and flag writes SHALL be independent; both enabled in one cycle SHALL both commit.
REQ-026 Both read ports addressing the same register SHALL return identical data, including bypass.
REQ-027 Flags SHALL have no bypass: carry_q changes only after the capturing edge.
REQ-028 Unknown/X on we or flag_we is a bench error; no defined behaviour is required.

Reset
REQ-029 rst=1 at a rising edge SHALL clear all registers, carry_q, zero_q and wr_cnt to 0.
REQ-030 rst SHALL take precedence over we and flag_we in the same cycle; that write SHALL be discarded.
REQ-031 While rst=1, combinational reads SHALL still operate, and bypass SHALL be suppressed so rd1/rd2 show stored values.
REQ-032 Reset asserted mid-sequence SHALL take effect on the next edge regardless of pending writes; no state survives.

Verification
REQ-033 Reset then read: rst=1 one cycle, ra1=5, ra2=31 -> rd1=0, rd2=0, carry_q=0, zero_q=0, wr_cnt=0.
REQ-034 Write/readback: we=1, wa=3, wd=0x00012D3E (0xCE42+0x5EFB+1), edge; we=0, ra1=3 -> rd1=0x00012D3E, wr_cnt=1.
REQ-035 Register 0 protection: we=1, wa=0, wd=0xFFFFFFFF, edge; ra1=0 -> rd1=0, wr_cnt unchanged; same-cycle bypass also gives rd1=0.
REQ-036 Bypass: reg7=0x56E0; same cycle we=1, wa=7, wd=0xA759, ra1=ra2=7 -> rd1=rd2=0xA759 before the edge, and stored value 0xA759 after it.
REQ-037 Flags: flag_we=1, cout_in=1, zero_in=0, edge -> carry_q=1, zero_q=0; then flag_we=0, cout_in=0, edge -> carry_q still 1.
REQ-038 Reset precedence: rst=1, we=1, wa=4, wd=0x1234, flag_we=1, cout_in=1, edge -> reg4=0, carry_q=0, wr_cnt=0.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: register file for the ALU32 datapath.
// Two combinational read ports with same-cycle write bypass, one write port,
// a carry/zero status-flag pair and a wrapping count of committed writes.
// Register 0 is hard-wired to zero. Reset is synchronous and active-high and
// overrides every write in the cycle it is sampled.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              flag_we,
  input  logic              cout_in,
  input  logic              zero_in,
  output logic              carry_q,
  output logic              zero_q,
  output logic [15:0]       wr_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 exists only to keep indexing uniform; it is cleared by reset,
  // never written, and masked to zero on both read ports.
  logic [WIDTH-1:0] regs [DEPTH];

  // A write commits only outside reset and never to register 0. The same
  // qualifier drives the bypass, so a discarded write is never forwarded.
  logic commit;

  // Write-commit qualifier shared by storage, counter and bypass.
  always_comb begin
    commit = we && !rst && (wa != '0);
  end

  // Register array: cleared by reset, loaded on a committed write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wa] <= wd;
    end
  end

  // Committed-write counter: free-running 16-bit wrap, never saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (commit) begin
      wr_cnt <= wr_cnt + 16'd1;
    end
  end

  // Status flags: captured on flag_we, otherwise held; no bypass path.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (flag_we) begin
      carry_q <= cout_in;
      zero_q  <= zero_in;
    end
  end

  // Read ports: register 0 reads zero, a same-cycle committed write to the
  // addressed register is forwarded, otherwise the stored value is shown.
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (commit && (ra1 == wa)) begin
      rd1 = wd;
    end
    if (commit && (ra2 == wa)) begin
      rd2 = wd;
    end
    if (ra1 == '0) begin
      rd1 = '0;
    end
    if (ra2 == '0) begin
      rd2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks with literal expectations followed by random
// traffic compared every cycle against an array-based reference model, and
// a long write burst that walks wr_cnt through its 16-bit wrap.
module tb_reg_file;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [ADDR_W-1:0] ra1, ra2, wa;
  logic [WIDTH-1:0]  rd1, rd2, wd;
  logic              we, flag_we, cout_in, zero_in;
  logic              carry_q, zero_q;
  logic [15:0]       wr_cnt;

  reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .flag_we (flag_we),
    .cout_in (cout_in),
    .zero_in (zero_in),
    .carry_q (carry_q),
    .zero_q  (zero_q),
    .wr_cnt  (wr_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_carry, m_zero;
  logic [15:0]      m_cnt;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_carry = 1'b0;
    m_zero  = 1'b0;
    m_cnt   = '0;
  end

  // Architectural effect of each rising edge.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_carry = 1'b0;
      m_zero  = 1'b0;
      m_cnt   = '0;
    end else begin
      if (we === 1'b1 && wa != 0) begin
        m_mem[wa] = wd;
        m_cnt     = m_cnt + 16'd1;
      end
      if (flag_we === 1'b1) begin
        m_carry = cout_in;
        m_zero  = zero_in;
      end
    end
  end

  // What a read port must show for address a given the current inputs.
  function automatic logic [WIDTH-1:0] exp_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (rst == 1'b0 && we == 1'b1 && wa == a) return wd;
    return m_mem[a];
  endfunction

  // Compare process: every cycle, mid-period, all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("rd1", rd1, exp_read(ra1));
      check("rd2", rd2, exp_read(ra2));
      check("carry_q", {31'b0, carry_q}, {31'b0, m_carry});
      check("zero_q", {31'b0, zero_q}, {31'b0, m_zero});
      check("wr_cnt", {16'b0, wr_cnt}, {16'b0, m_cnt});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; flag_we = 1'b0; wa = '0; wd = '0;
    cout_in = 1'b0; zero_in = 1'b0;
  endtask

  task automatic rand_cycle(input bit allow_rst);
    rst     = allow_rst && ($urandom_range(0, 49) == 0);
    we      = $urandom_range(0, 2) != 0;
    wa      = ADDR_W'($urandom_range(0, DEPTH - 1));
    wd      = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom();
    flag_we = $urandom_range(0, 1) == 1;
    cout_in = $urandom_range(0, 1) == 1;
    zero_in = $urandom_range(0, 1) == 1;
    ra1     = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1));
    ra2     = ($urandom_range(0, 3) == 0) ? ra1 : ADDR_W'($urandom_range(0, DEPTH - 1));
    cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; ra1 = '0; ra2 = '0;
    idle();
    repeat (2) cyc();
    check_en = 1'b1;

    // Reset then read.
    ra1 = 5; ra2 = 31;
    mid();
    check("rst_rd1", rd1, 32'h0);
    check("rst_rd2", rd2, 32'h0);
    check("rst_carry", {31'b0, carry_q}, 32'h0);
    check("rst_zero", {31'b0, zero_q}, 32'h0);
    check("rst_wr_cnt", {16'b0, wr_cnt}, 32'h0);
    cyc();
    rst = 1'b0;

    // Write then read back.
    we = 1'b1; wa = 3; wd = 32'h0001_2D3E;
    cyc();
    idle(); ra1 = 3;
    mid();
    check("wb_rd1", rd1, 32'h0001_2D3E);
    check("wb_wr_cnt", {16'b0, wr_cnt}, 32'h1);
    cyc();

    // Register 0 protection, including same-cycle bypass.
    we = 1'b1; wa = 0; wd = 32'hFFFF_FFFF; ra1 = 0;
    mid();
    check("r0_bypass", rd1, 32'h0);
    cyc();
    idle();
    mid();
    check("r0_rd1", rd1, 32'h0);
    check("r0_wr_cnt", {16'b0, wr_cnt}, 32'h1);
    cyc();

    // Bypass on both ports to the same register.
    we = 1'b1; wa = 7; wd = 32'h56E0;
    cyc();
    wd = 32'hA759; ra1 = 7; ra2 = 7;
    mid();
    check("byp_rd1", rd1, 32'hA759);
    check("byp_rd2", rd2, 32'hA759);
    cyc();
    idle();
    mid();
    check("byp_stored", rd1, 32'hA759);
    check("byp_wr_cnt", {16'b0, wr_cnt}, 32'h3);
    cyc();

    // Flags capture, no bypass, hold.
    flag_we = 1'b1; cout_in = 1'b1; zero_in = 1'b0;
    mid();
    check("flag_nobypass", {31'b0, carry_q}, 32'h0);
    cyc();
    flag_we = 1'b0; cout_in = 1'b0;
    mid();
    check("flag_carry", {31'b0, carry_q}, 32'h1);
    check("flag_zero", {31'b0, zero_q}, 32'h0);
    cyc();
    mid();
    check("flag_hold", {31'b0, carry_q}, 32'h1);
    cyc();

    // Reset precedence over writes; bypass suppressed during reset.
    rst = 1'b1; we = 1'b1; wa = 4; wd = 32'h1234;
    flag_we = 1'b1; cout_in = 1'b1; ra1 = 4; ra2 = 3;
    mid();
    check("rstp_nobypass", rd1, 32'h0);
    check("rstp_stored", rd2, 32'h0001_2D3E);
    cyc();
    rst = 1'b0; idle();
    mid();
    check("rstp_reg4", rd1, 32'h0);
    check("rstp_reg3", rd2, 32'h0);
    check("rstp_carry", {31'b0, carry_q}, 32'h0);
    check("rstp_wr_cnt", {16'b0, wr_cnt}, 32'h0);
    cyc();

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);

    // Counter wrap: reset, then 65535 committed writes, then one more.
    rst = 1'b1; idle();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      we = 1'b1; wa = ADDR_W'($urandom_range(1, DEPTH - 1)); wd = $urandom();
      ra1 = ADDR_W'($urandom_range(0, DEPTH - 1)); ra2 = wa;
      cyc();
    end
    idle();
    mid();
    check("wrap_ffff", {16'b0, wr_cnt}, 32'h0000_FFFF);
    we = 1'b1; wa = 1; wd = 32'hDEAD_BEEF;
    cyc();
    idle();
    mid();
    check("wrap_zero", {16'b0, wr_cnt}, 32'h0);
    cyc();

    // A little more random traffic after the wrap.
    for (int i = 0; i < 500; i++) rand_cycle(1'b0);
    idle();
    cyc();
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
